rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (we/rd/wd) between NREQ write-back requesters, e.g. ALU, load unit and CSR/debug.
- Uses round-robin arbitration with valid/ready handshakes.
- Keeps a 32-entry busy scoreboard: issued destinations are marked pending until their write lands, so decode can stall on RAW and WAW hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
NREQ, 3, number of write-back requesters (2..8)
XLEN, 32, data width
AW, 5, register address width (2**AW registers)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  requester i has a write-back pending
req_rd  in  NREQ*AW  destination register per requester, packed, index i at [i*AW +: AW]
req_data  in  NREQ*XLEN  write data per requester, packed likewise
req_ready  out  NREQ  one-hot grant; transfer when valid&ready
rf_we  out  1  register-file write enable
rf_rd  out  AW  register-file write address
rf_wd  out  XLEN  register-file write data
iss_valid  in  1  decode issues an instruction with destination iss_rd
iss_rd  in  AW  destination register being issued
iss_ready  out  1  issue accepted (no WAW conflict)
rs1  in  AW  decode source 1 query
rs2  in  AW  decode source 2 query
rs1_busy  out  1  rs1 has a pending write
rs2_busy  out  1  rs2 has a pending write
busy_vec  out  2**AW  scoreboard state, bit 0 always 0
wb_err  out  1  sticky: write-back accepted for a non-busy register

Behaviour:
Clock and reset
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: rf_we=0, rf_rd=0, rf_wd=0, busy_vec=0, wb_err=0, round-robin pointer=0.
- Reset mid-operation discards any in-flight write; rf_we is 0 on the first edge after release.

Arbitration
- req_ready is combinational from req_valid and the pointer.
- Grant goes to the first asserted req_valid, searching from index ptr upward with wrap-around. req_ready is all-zero if no valid.
- On each grant to index g, ptr <= (g+1) mod NREQ. Ptr is unchanged when nothing is granted.
- The output stage always drains in one cycle, so one grant per cycle is possible. There is no back-pressure beyond losing arbitration.
- Requesters hold valid, rd and data stable until ready. The arbiter must not depend on valid dropping early.

Write path
- Grant in cycle t: on edge t+1, register rf_we=1, rf_rd=req_rd[g], rf_wd=req_data[g]. Latency is 1.
- If no grant, rf_we <= 0 and rf_rd/rf_wd hold their values.
- A granted request with rd==0 is consumed (ready=1) but rf_we <= 0.

Scoreboard
- Set: iss_valid & iss_ready & iss_rd!=0 sets busy[iss_rd] at the edge.
- iss_ready = !busy[iss_rd] | (iss_rd==0).
- Clear: busy[rf_rd] clears at the edge where rf_we=1, i.e. the edge the register file commits. Busy therefore stays high through the acceptance-to-write cycle, covering the read-before-write window.
- Same-edge set and clear of the same index: set wins. This is legal because the clearing write is the older one.
- rsN_busy = busy[rsN] & (rsN!=0). These outputs are combinational from the current state, with no bypass.
- busy[0] is never set.

Error
- wb_err sets when a grant has rd!=0 and busy[rd]==0 at grant time.
- It clears only on reset.

Decomposition:
- Package rf_pkg: XLEN, AW, NREG=2**AW, and the REG_ZERO constant.
- One natural sub-module, rr_arbiter (parameter N): req -> one-hot gnt plus pointer register. It is reusable for other shared ports.
- Scoreboard and output register stay in rf_wb_arbiter.

Test Plan:
- Reset then idle: rst_n low mid-run with busy_vec=0x0000_0F00 and rf_we=1 -> immediately busy_vec=0, rf_we=0, wb_err=0.
- Single write: issue rd=5; next cycle req_valid[1]=1, rd=5, data=0xDEADBEEF -> req_ready=3'b010, rf_we=1/rf_rd=5/rf_wd=0xDEADBEEF one cycle later. busy[5] stays 1 that cycle and reads 0 after the edge.
- Round-robin fairness: all three valid continuously for 6 cycles from reset -> grant order 0,1,2,0,1,2 and rf_we held high for 6 consecutive cycles.
- Hazards: busy[7]=1 with rs1=7, rs2=0 -> rs1_busy=1, rs2_busy=0. iss_rd=7 -> iss_ready=0. iss_rd=0 -> iss_ready=1 with busy_vec unchanged.
- Simultaneous set/clear: the commit of rd=9 coincides with a new issue to rd=9 -> busy[9] remains 1.
- Corner cases: write-back rd=0 with data=0x1 -> ready=1, rf_we=0, wb_err=0. Write-back rd=12 with busy[12]=0 -> rf_we=1 and wb_err sticks at 1.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants for the register-file write-back path.
// Data width, register address width and the hard-wired zero register.
package rf_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 2 ** AW;

  localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a pointer
// that moves to one past the last winner.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   sum;
  logic [IW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      j = sum[IW-1:0];
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_o) begin
      if (idx_o == IW'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = idx_o + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with a busy scoreboard
// for RAW/WAW stalls in decode.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter  int NREQ = 3,
  parameter  int XLEN = rf_pkg::XLEN,
  parameter  int AW   = rf_pkg::AW,
  localparam int NR   = 2 ** AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_we,
  output logic [AW-1:0]      rf_rd,
  output logic [XLEN-1:0]    rf_wd,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_rd,
  output logic               iss_ready,
  input  logic [AW-1:0]      rs1,
  input  logic [AW-1:0]      rs2,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic [NR-1:0]      busy_vec,
  output logic               wb_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] RZ = '0;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;

  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_wd;

  logic            we_q, we_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [NR-1:0]   busy_q, busy_d;
  logic            err_q, err_d;
  logic            iss_set;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_valid),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign req_ready = gnt;

  always_comb begin
    sel_rd = '0;
    sel_wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_rd = req_rd[i*AW +: AW];
        sel_wd = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // rd==0 grants are consumed without touching the register file
  always_comb begin
    we_d = gnt_any && (sel_rd != RZ);
    rd_d = rd_q;
    wd_d = wd_q;
    if (we_d) begin
      rd_d = sel_rd;
      wd_d = sel_wd;
    end
  end

  assign iss_ready = !busy_q[iss_rd] || (iss_rd == RZ);
  assign iss_set   = iss_valid && iss_ready && (iss_rd != RZ);

  // Clear on commit, then set: a same-edge reissue keeps the bit
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (iss_set) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    err_d = err_q;
    if (gnt_any && (sel_rd != RZ) && !busy_q[sel_rd]) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      wd_q   <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_rd    = rd_q;
  assign rf_wd    = wd_q;
  assign busy_vec = busy_q;
  assign wb_err   = err_q;

  assign rs1_busy = busy_q[rs1] && (rs1 != RZ);
  assign rs2_busy = busy_q[rs2] && (rs2 != RZ);

endmodule
